// File: rtl/aes_core_scheduler_if.sv
// Request/grant and round-control bundle between requesters and the AES round scheduler.
interface aes_core_scheduler_if;
    logic [1:0] req_valid;
    logic [1:0] req_mode0;
    logic [1:0] req_mode1;
    logic [1:0] req_dec;
    logic       hold;
    logic [1:0] gnt;
    logic       busy;
    logic       core_en;
    logic [1:0] core_mode;
    logic       core_dec;
    logic [3:0] round;
    logic [3:0] key_sel;
    logic       first;
    logic       last;
    logic       done;
    logic       done_id;
    logic       err;

    modport master (
        output req_valid, req_mode0, req_mode1, req_dec, hold,
        input  gnt, busy, core_en, core_mode, core_dec, round, key_sel,
               first, last, done, done_id, err
    );

    modport slave (
        input  req_valid, req_mode0, req_mode1, req_dec, hold,
        output gnt, busy, core_en, core_mode, core_dec, round, key_sel,
               first, last, done, done_id, err
    );
endinterface

// File: rtl/aes_core_scheduler.sv
// Two-requester round-robin scheduler sequencing AES rounds for a shared core.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch job on grant
// RUN   | step rounds 0..Nr, frozen while hold is high
// DONE  | one-cycle completion pulse (err for illegal mode)
module aes_core_scheduler #(
    parameter int NR128 = 10,
    parameter int NR192 = 12,
    parameter int NR256 = 14
) (
    input logic                clk,
    input logic                rst,
    aes_core_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       id_q, id_d;
    logic [1:0] mode_q, mode_d;
    logic       dec_q, dec_d;
    logic       err_q, err_d;
    logic       rr_q, rr_d;

    logic       pick;
    logic [1:0] pick_mode;
    logic [3:0] nr;
    logic [1:0] gnt_c;
    logic       busy_c, core_en_c, first_c, last_c, done_c;
    logic [3:0] round_c, key_sel_c;

    // Round count of the latched job; the illegal mode never reaches RUN.
    always_comb begin
        case (mode_q)
            2'd0:    nr = 4'(NR128);
            2'd1:    nr = 4'(NR192);
            default: nr = 4'(NR256);
        endcase
    end

    // Tie goes to the requester not granted last; a lone requester wins outright.
    always_comb begin
        pick      = (bus.req_valid == 2'b11) ? ~rr_q : bus.req_valid[1];
        pick_mode = pick ? bus.req_mode1 : bus.req_mode0;
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        id_d      = id_q;
        mode_d    = mode_q;
        dec_d     = dec_q;
        err_d     = err_q;
        rr_d      = rr_q;
        gnt_c     = 2'b00;
        busy_c    = 1'b0;
        core_en_c = 1'b0;
        first_c   = 1'b0;
        last_c    = 1'b0;
        done_c    = 1'b0;
        round_c   = 4'd0;
        key_sel_c = 4'd0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    gnt_c       = 2'b00;
                    gnt_c[pick] = 1'b1;
                    id_d        = pick;
                    rr_d        = pick;
                    mode_d      = pick_mode;
                    dec_d       = bus.req_dec[pick];
                    err_d       = (pick_mode == 2'd3);
                    round_d     = 4'd0;
                    state_d     = (pick_mode == 2'd3) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_c    = 1'b1;
                core_en_c = ~bus.hold;
                first_c   = (round_q == 4'd0);
                last_c    = (round_q == nr);
                round_c   = round_q;
                // round never exceeds nr, so nr - round cannot wrap
                key_sel_c = dec_q ? (nr - round_q) : round_q;
                if (!bus.hold) begin
                    if (round_q == nr) state_d = DONE;
                    else               round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and job registers; reset aborts any job and favours requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            id_q    <= 1'b0;
            mode_q  <= 2'd0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.gnt       = rst ? 2'b00 : gnt_c;
    assign bus.busy      = busy_c;
    assign bus.core_en   = core_en_c;
    assign bus.core_mode = mode_q;
    assign bus.core_dec  = dec_q;
    assign bus.round     = round_c;
    assign bus.key_sel   = key_sel_c;
    assign bus.first     = first_c;
    assign bus.last      = last_c;
    assign bus.done      = done_c;
    assign bus.done_id   = done_c & id_q;
    assign bus.err       = done_c & err_q;
endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler: table of jobs plus stall, tie and reset sequences.
module tb_aes_core_scheduler;
    logic clk;
    logic rst;
    aes_core_scheduler_if bus ();

    aes_core_scheduler #(.NR128(10), .NR192(12), .NR256(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] dec;
        logic       hold;
        logic [1:0] e_gnt;
        int         e_nr;
        logic       e_id;
        logic       e_err;
        logic [1:0] e_mode;
        logic       e_dec;
    } row_t;

    row_t rows[7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt"}, bus.gnt, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_core_en"}, bus.core_en, 0);
        chk({nm, "_core_mode"}, bus.core_mode, 0);
        chk({nm, "_core_dec"}, bus.core_dec, 0);
        chk({nm, "_round"}, bus.round, 0);
        chk({nm, "_key_sel"}, bus.key_sel, 0);
        chk({nm, "_first"}, bus.first, 0);
        chk({nm, "_last"}, bus.last, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_done_id"}, bus.done_id, 0);
        chk({nm, "_err"}, bus.err, 0);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic run_row(input row_t r);
        bus.req_valid = r.rv;
        bus.req_mode0 = r.m0;
        bus.req_mode1 = r.m1;
        bus.req_dec   = r.dec;
        bus.hold      = r.hold;
        #1;
        chk("row_gnt", bus.gnt, r.e_gnt);
        chk("row_idle_busy", bus.busy, 0);
        nxt();
        // scrambled inputs must not disturb the latched job
        bus.req_valid = 2'b00;
        bus.req_mode0 = 2'd3;
        bus.req_mode1 = 2'd3;
        bus.req_dec   = ~r.dec;
        bus.hold      = 1'b0;
        #1;
        if (!r.e_err) begin
            for (int k = 0; k <= r.e_nr; k++) begin
                chk("run_busy", bus.busy, 1);
                chk("run_core_en", bus.core_en, 1);
                chk("run_round", bus.round, k);
                chk("run_key_sel", bus.key_sel, r.e_dec ? (r.e_nr - k) : k);
                chk("run_first", bus.first, (k == 0) ? 1 : 0);
                chk("run_last", bus.last, (k == r.e_nr) ? 1 : 0);
                chk("run_done", bus.done, 0);
                chk("run_core_mode", bus.core_mode, r.e_mode);
                chk("run_core_dec", bus.core_dec, r.e_dec);
                nxt();
            end
        end
        bus.hold = r.hold;
        bus.req_valid = r.rv;
        #1;
        chk("done_pulse", bus.done, 1);
        chk("done_id", bus.done_id, r.e_id);
        chk("done_err", bus.err, r.e_err);
        chk("done_busy", bus.busy, 1);
        chk("done_core_en", bus.core_en, 0);
        chk("done_no_gnt", bus.gnt, 0);
        chk("done_first_last", {bus.first, bus.last}, 0);
        chk("done_core_mode", bus.core_mode, r.e_mode);
        nxt();
        bus.req_valid = 2'b00;
        bus.hold = 1'b0;
        #1;
        chk("post_done", bus.done, 0);
        chk("post_busy", bus.busy, 0);
    endtask

    initial begin
        int exp_round;
        int ng;
        int nd;
        int got;
        logic [1:0] gval[3];
        int gcyc[3];
        int dcyc[3];

        //           rv     m0    m1    dec    hold  gnt    nr  id    err   mode  dec
        rows[0] = '{2'b01, 2'd0, 2'd0, 2'b00, 1'b0, 2'b01, 10, 1'b0, 1'b0, 2'd0, 1'b0};
        rows[1] = '{2'b10, 2'd0, 2'd2, 2'b10, 1'b0, 2'b10, 14, 1'b1, 1'b0, 2'd2, 1'b1};
        rows[2] = '{2'b01, 2'd1, 2'd0, 2'b01, 1'b1, 2'b01, 12, 1'b0, 1'b0, 2'd1, 1'b1};
        rows[3] = '{2'b01, 2'd3, 2'd0, 2'b00, 1'b0, 2'b01, 0,  1'b0, 1'b1, 2'd3, 1'b0};
        rows[4] = '{2'b10, 2'd0, 2'd3, 2'b10, 1'b0, 2'b10, 0,  1'b1, 1'b1, 2'd3, 1'b1};
        rows[5] = '{2'b11, 2'd0, 2'd1, 2'b00, 1'b0, 2'b01, 10, 1'b0, 1'b0, 2'd0, 1'b0};
        rows[6] = '{2'b11, 2'd2, 2'd1, 2'b10, 1'b0, 2'b10, 12, 1'b1, 1'b0, 2'd1, 1'b1};

        // reset with requests present: rst wins, everything zero
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_mode0 = 2'd0;
        bus.req_mode1 = 2'd0;
        bus.req_dec   = 2'b00;
        bus.hold      = 1'b0;
        nxt();
        nxt();
        chk_all_zero("reset");
        rst = 1'b0;
        bus.req_valid = 2'b00;

        for (int i = 0; i < 7; i++) run_row(rows[i]);

        // stall: mode 1 job, hold for 3 cycles while round==5
        bus.req_valid = 2'b01;
        bus.req_mode0 = 2'd1;
        bus.req_dec   = 2'b00;
        #1;
        chk("stall_gnt", bus.gnt, 2'b01);
        for (int c = 1; c <= 17; c++) begin
            nxt();
            bus.req_valid = 2'b00;
            bus.hold = (c >= 6 && c <= 8);
            #1;
            exp_round = (c <= 5) ? c - 1 : ((c <= 9) ? 5 : c - 4);
            if (c == 17) begin
                chk("stall_done", bus.done, 1);
                chk("stall_done_id", bus.done_id, 0);
            end else begin
                chk("stall_round", bus.round, exp_round);
                chk("stall_core_en", bus.core_en, (c >= 6 && c <= 8) ? 0 : 1);
                chk("stall_last", bus.last, (c == 16) ? 1 : 0);
                chk("stall_done_early", bus.done, 0);
            end
        end
        bus.hold = 1'b0;
        nxt();

        // tie: both requesters held valid from reset
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_mode0 = 2'd0;
        bus.req_mode1 = 2'd0;
        bus.req_dec   = 2'b00;
        ng = 0;
        nd = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (bus.gnt != 2'b00 && ng < 3) begin
                gval[ng] = bus.gnt;
                gcyc[ng] = cyc;
                ng++;
            end
            if (bus.done && nd < 3) begin
                dcyc[nd] = cyc;
                nd++;
            end
            if (ng == 3) break;
            @(posedge clk);
            #1;
        end
        chk("tie_grant_count", ng, 3);
        if (ng == 3) begin
            chk("tie_gnt0", gval[0], 2'b01);
            chk("tie_gnt1", gval[1], 2'b10);
            chk("tie_gnt2", gval[2], 2'b01);
            chk("tie_gcyc0", gcyc[0], 0);
            chk("tie_gap1", gcyc[1], dcyc[0] + 1);
            chk("tie_gap2", gcyc[2], dcyc[1] + 1);
            chk("tie_done0", dcyc[0], 12);
        end

        // mid-job reset at round 6, requester 1 left pending
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        chk("mid_gnt", bus.gnt, 2'b01);
        for (int c = 1; c <= 7; c++) begin
            nxt();
            bus.req_valid = 2'b10;
        end
        #1;
        chk("mid_round6", bus.round, 6);
        rst = 1'b1;
        nxt();
        #1;
        chk_all_zero("mid_reset");
        rst = 1'b0;
        #1;
        chk("mid_regrant", bus.gnt, 2'b10);
        got = 0;
        for (int c = 1; c <= 30; c++) begin
            nxt();
            bus.req_valid = 2'b00;
            #1;
            if (bus.done) begin
                got = c;
                break;
            end
        end
        chk("mid_done_latency", got, 12);
        chk("mid_done_id", bus.done_id, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
